seven_segment_mux_driver: RTL and testbench

Multi-digit, time-multiplexed seven-segment display driver. It is the parametrised successor to the single-digit hex-to-segment encoder: it scans NUM_DIGITS hex digits onto one shared segment bus, one digit at a time. It adds double-buffered value loading, a tear-free frame-boundary update, anti-ghosting blanking, leading-zero suppression and configurable output polarity. It sits between the UART/datapath logic and the board's segment and digit-select pins.

---
 rtl/seven_segment_mux_driver.sv | 156 +++++++++++++++
 tb/tb_seven_segment_mux_driver.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux_driver.sv
// seven_segment_mux_driver
// Time-multiplexed driver that scans NUM_DIGITS hex digits onto one shared
// seven-segment bus. A shadow register takes new values at any time. The
// shown value changes only at a frame boundary, so a frame never mixes old
// and new digits. Each slot opens with a short all-off gap to stop ghosting
// between digits. Leading zeros can be suppressed, and both the segment and
// digit-enable polarities can be inverted for the board in use.

module seven_segment_mux_driver #(
    parameter int NUM_DIGITS         = 4,
    parameter int CLKS_PER_DIGIT     = 25000,
    parameter int BLANK_CLKS         = 2,
    parameter int SEG_ACTIVE_LOW     = 0,
    parameter int DIGIT_ACTIVE_LOW   = 1,
    parameter int LEADING_ZERO_BLANK = 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Load,
    input  logic [4*NUM_DIGITS-1:0]   i_Value,
    input  logic                      i_Blank,
    output logic [6:0]                o_Segments,
    output logic [NUM_DIGITS-1:0]     o_Digit_En,
    output logic                      o_Frame_Done
);

    localparam int CNT_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Output levels that mean "nothing lit" for the selected polarity
    localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW != 0}};

    logic [CNT_W-1:0]      refresh_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic [VAL_W-1:0]      shadow_reg;
    logic [VAL_W-1:0]      active_reg;
    logic                  pending;

    logic                  slot_end;
    logic                  frame_wrap;
    logic                  zeros_above;
    logic [NUM_DIGITS-1:0] suppressed;
    logic [3:0]            cur_nibble;
    logic                  cur_suppressed;
    logic                  past_blank;
    logic                  digit_lit;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] en_next;

    // Active-high A..G pattern for one hex nibble
    function automatic logic [6:0] hex_to_segments(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    assign slot_end   = (refresh_cnt == CNT_LAST);
    assign frame_wrap = slot_end && (digit_idx == IDX_LAST);

    // Slot timer and digit index; the index advances only when a slot ends
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (slot_end) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    // Double buffer: the commit at the wrap reads the old shadow, so a load
    // on the wrap cycle itself waits in the shadow until the next wrap
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            shadow_reg <= '0;
            active_reg <= '0;
            pending    <= 1'b0;
        end else begin
            if (frame_wrap && pending) begin
                active_reg <= shadow_reg;
                pending    <= 1'b0;
            end
            if (i_Load) begin
                shadow_reg <= i_Value;
                pending    <= 1'b1;
            end
        end
    end

    // Leading-zero mask, built from the most significant digit downward
    always_comb begin
        zeros_above = 1'b1;
        suppressed  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zeros_above   = zeros_above && (active_reg[4*k +: 4] == 4'h0);
            suppressed[k] = (LEADING_ZERO_BLANK != 0) && (k > 0) && zeros_above;
        end
    end

    // Choose the digit in the current slot and decide whether it is lit
    always_comb begin
        cur_nibble     = 4'h0;
        cur_suppressed = 1'b0;
        en_next        = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_nibble     = active_reg[4*k +: 4];
                cur_suppressed = suppressed[k];
            end
        end
        past_blank = (int'(refresh_cnt) >= BLANK_CLKS);
        digit_lit  = past_blank && !i_Blank && !cur_suppressed;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            en_next[k] = digit_lit && (digit_idx == IDX_W'(k));
        end
        seg_next = digit_lit ? hex_to_segments(cur_nibble) : 7'h00;
    end

    // Register the pins and apply the board polarity
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Segments   <= SEG_OFF;
            o_Digit_En   <= DIGIT_OFF;
            o_Frame_Done <= 1'b0;
        end else begin
            o_Segments   <= (SEG_ACTIVE_LOW != 0) ? ~seg_next : seg_next;
            o_Digit_En   <= (DIGIT_ACTIVE_LOW != 0) ? ~en_next : en_next;
            o_Frame_Done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// tb_seven_segment_mux_driver
// Drives two instances from the same stimulus: the main one uses active-high
// segments with leading-zero suppression, and the alternate one uses
// active-low segments with no suppression. A frame-level reference model
// predicts both sets of pins every cycle.

module tb_seven_segment_mux_driver;

    localparam int ND    = 4;
    localparam int CPD   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * CPD;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic        i_Clk = 1'b0;
    logic        i_Reset;
    logic        i_Load;
    logic [15:0] i_Value;
    logic        i_Blank;

    logic [6:0]  o_Segments;
    logic [3:0]  o_Digit_En;
    logic        o_Frame_Done;
    logic [6:0]  seg_alt;
    logic [3:0]  en_alt;
    logic        fd_alt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_tick;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;
    logic [6:0]  exp_seg, exp_seg_alt;
    logic [3:0]  exp_en, exp_en_alt;
    logic        exp_fd, exp_fd_alt;

    logic [23:0] got_all;
    logic [23:0] exp_all;
    localparam logic [23:0] RESET_ALL = {7'h00, 4'hF, 1'b0, 7'h7F, 4'hF, 1'b0};

    assign got_all = {o_Segments, o_Digit_En, o_Frame_Done, seg_alt, en_alt, fd_alt};
    assign exp_all = {exp_seg, exp_en, exp_fd, exp_seg_alt, exp_en_alt, exp_fd_alt};

    seven_segment_mux_driver #(
        .NUM_DIGITS(ND), .CLKS_PER_DIGIT(CPD), .BLANK_CLKS(BLANK),
        .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(1), .LEADING_ZERO_BLANK(1)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Load(i_Load), .i_Value(i_Value),
        .i_Blank(i_Blank), .o_Segments(o_Segments), .o_Digit_En(o_Digit_En),
        .o_Frame_Done(o_Frame_Done)
    );

    seven_segment_mux_driver #(
        .NUM_DIGITS(ND), .CLKS_PER_DIGIT(CPD), .BLANK_CLKS(BLANK),
        .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1), .LEADING_ZERO_BLANK(0)
    ) dut_alt (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Load(i_Load), .i_Value(i_Value),
        .i_Blank(i_Blank), .o_Segments(seg_alt), .o_Digit_En(en_alt),
        .o_Frame_Done(fd_alt)
    );

    always #5 i_Clk = ~i_Clk;

    // Reference model: position in the frame comes from a plain cycle count
    always @(posedge i_Clk or posedge i_Reset) begin
        int slot, offs, ndig;
        logic [3:0] nib;
        logic lit_base, lit_main;
        if (i_Reset) begin
            m_tick      = 0;
            m_active    = '0;
            m_shadow    = '0;
            m_pending   = 1'b0;
            exp_seg     = 7'h00;
            exp_en      = 4'hF;
            exp_fd      = 1'b0;
            exp_seg_alt = 7'h7F;
            exp_en_alt  = 4'hF;
            exp_fd_alt  = 1'b0;
        end else begin
            slot = (m_tick / CPD) % ND;
            offs = m_tick % CPD;
            ndig = 1;
            while (ndig < ND && (m_active >> (4 * ndig)) != 16'h0) ndig++;
            nib      = 4'((m_active >> (4 * slot)) & 16'hF);
            lit_base = (offs >= BLANK) && !i_Blank;
            lit_main = lit_base && (slot < ndig);
            exp_en      = lit_main ? 4'(~(4'b0001 << slot)) : 4'hF;
            exp_seg     = lit_main ? SEG_TABLE[nib] : 7'h00;
            exp_en_alt  = lit_base ? 4'(~(4'b0001 << slot)) : 4'hF;
            exp_seg_alt = lit_base ? ~SEG_TABLE[nib] : 7'h7F;
            exp_fd      = ((m_tick % FRAME) == FRAME - 1);
            exp_fd_alt  = exp_fd;
            if (exp_fd && m_pending) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (i_Load) begin
                m_shadow  = i_Value;
                m_pending = 1'b1;
            end
            m_tick++;
        end
    end

    // Reset levels, then two idle frames showing a lone zero on digit 0
    task automatic test_reset();
        int lit_cnt;
        int fd_cnt;
        i_Reset = 1'b1; i_Load = 1'b0; i_Value = '0; i_Blank = 1'b0;
        repeat (2) @(negedge i_Clk);
        n_checks++;
        if (got_all !== RESET_ALL) begin
            n_fail++;
            $display("[TB] FAIL reset_levels: got %h expected %h", got_all, RESET_ALL);
        end
        i_Reset = 1'b0;
        lit_cnt = 0; fd_cnt = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge i_Clk);
            n_checks++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL idle_scan c=%0d: got %h expected %h", c, got_all, exp_all);
            end
            if (o_Digit_En == 4'b1110 && o_Segments == 7'h7E) lit_cnt++;
            if (o_Frame_Done) fd_cnt++;
        end
        n_checks++;
        if (lit_cnt !== 12) begin
            n_fail++;
            $display("[TB] FAIL idle_digit0_lit: got %0d expected 12", lit_cnt);
        end
        n_checks++;
        if (fd_cnt !== 2) begin
            n_fail++;
            $display("[TB] FAIL idle_frame_done: got %0d expected 2", fd_cnt);
        end
    endtask

    // Load 12AF; old frame keeps showing 0, the next two frames show 12AF
    task automatic test_load_value();
        int n_old, n0, n1, n2, n3;
        n_old = 0; n0 = 0; n1 = 0; n2 = 0; n3 = 0;
        i_Load = 1'b1; i_Value = 16'h12AF;
        for (int c = 0; c < 96; c++) begin
            @(negedge i_Clk);
            i_Load = 1'b0;
            n_checks++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL load_scan c=%0d: got %h expected %h", c, got_all, exp_all);
            end
            if (o_Digit_En == 4'b1110 && o_Segments == 7'h7E) n_old++;
            if (o_Digit_En == 4'b1110 && o_Segments == 7'h47) n0++;
            if (o_Digit_En == 4'b1101 && o_Segments == 7'h77) n1++;
            if (o_Digit_En == 4'b1011 && o_Segments == 7'h6D) n2++;
            if (o_Digit_En == 4'b0111 && o_Segments == 7'h30) n3++;
        end
        n_checks++;
        if (n_old !== 6 || n0 !== 12 || n1 !== 12 || n2 !== 12 || n3 !== 12) begin
            n_fail++;
            $display("[TB] FAIL load_counts: got %0d/%0d/%0d/%0d/%0d expected 6/12/12/12/12",
                     n_old, n0, n1, n2, n3);
        end
    endtask

    // Two loads in one frame: only the second reaches the display
    task automatic test_last_write_wins();
        int n_d3_main, n_d2_main, n_d3_alt;
        n_d3_main = 0; n_d2_main = 0; n_d3_alt = 0;
        i_Load = 1'b1; i_Value = 16'h0005;
        for (int c = 0; c < 64; c++) begin
            @(negedge i_Clk);
            i_Load = (c == 9);
            if (c == 9) i_Value = 16'h0A00;
            n_checks++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL lww_scan c=%0d: got %h expected %h", c, got_all, exp_all);
            end
            if (c >= 32) begin
                if (o_Digit_En == 4'b0111) n_d3_main++;
                if (o_Digit_En == 4'b1011 && o_Segments == 7'h77) n_d2_main++;
                if (en_alt == 4'b0111 && seg_alt == 7'h01) n_d3_alt++;
            end
        end
        n_checks++;
        if (n_d3_main !== 0 || n_d2_main !== 6 || n_d3_alt !== 6) begin
            n_fail++;
            $display("[TB] FAIL lww_counts: got %0d/%0d/%0d expected 0/6/6",
                     n_d3_main, n_d2_main, n_d3_alt);
        end
    endtask

    // Load on the exact wrap cycle lands one frame late
    task automatic test_wrap_load();
        int n_early, n_late;
        n_early = 0; n_late = 0;
        i_Value = 16'h3333;
        for (int c = 0; c < 96; c++) begin
            @(negedge i_Clk);
            n_checks++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL wrapload_scan c=%0d: got %h expected %h", c, got_all, exp_all);
            end
            if (o_Segments == 7'h79 && o_Digit_En != 4'hF) begin
                if (c >= 32 && c < 64) n_early++;
                if (c >= 64) n_late++;
            end
            i_Load = (c == 30);
        end
        n_checks++;
        if (n_early !== 0 || n_late !== 24) begin
            n_fail++;
            $display("[TB] FAIL wrapload_counts: got %0d/%0d expected 0/24", n_early, n_late);
        end
    endtask

    // Random loads and blanking against the model
    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge i_Clk);
            n_checks++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL random_scan c=%0d: got %h expected %h", c, got_all, exp_all);
            end
            i_Load  = ($urandom_range(0, 11) == 0);
            i_Value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) i_Value = i_Value & 16'h00FF;
            i_Blank = ($urandom_range(0, 9) == 0);
        end
    endtask

    // Reset in the middle of digit 2, then one blanked frame, then zero
    task automatic test_reset_mid_frame();
        logic found;
        int   n_lit_blank, n_zero, n_other;
        found = 1'b0;
        n_lit_blank = 0; n_zero = 0; n_other = 0;
        i_Load = 1'b1; i_Value = 16'hFFFF; i_Blank = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge i_Clk);
            i_Load = 1'b0;
            n_checks++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL midreset_pre c=%0d: got %h expected %h", c, got_all, exp_all);
            end
            found = (m_active == 16'hFFFF) && ((m_tick % FRAME) == 20);
        end
        n_checks++;
        if (!found || o_Digit_En !== 4'b1011 || o_Segments !== 7'h47) begin
            n_fail++;
            $display("[TB] FAIL midreset_digit2: got found=%0b en=%b seg=%h expected 1/1011/47",
                     found, o_Digit_En, o_Segments);
        end
        #2;
        i_Reset = 1'b1;
        #1;
        n_checks++;
        if (got_all !== RESET_ALL) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h expected %h", got_all, RESET_ALL);
        end
        @(negedge i_Clk);
        n_checks++;
        if (got_all !== RESET_ALL) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: got %h expected %h", got_all, RESET_ALL);
        end
        i_Reset = 1'b0;
        i_Blank = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge i_Clk);
            n_checks++;
            if (got_all !== exp_all) begin
                n_fail++;
                $display("[TB] FAIL post_reset c=%0d: got %h expected %h", c, got_all, exp_all);
            end
            if (c < 32) begin
                if (o_Digit_En != 4'hF || en_alt != 4'hF) n_lit_blank++;
            end else begin
                if (o_Digit_En == 4'b1110 && o_Segments == 7'h7E) n_zero++;
                else if (o_Digit_En != 4'hF) n_other++;
            end
            if (c == 31) i_Blank = 1'b0;
        end
        n_checks++;
        if (n_lit_blank !== 0 || n_zero !== 6 || n_other !== 0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_counts: got %0d/%0d/%0d expected 0/6/0",
                     n_lit_blank, n_zero, n_other);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_load_value();
        test_last_write_wins();
        test_wrap_load();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
